// File: rtl/seq_checker_if.sv
// Bit-stream and status bundle between a serial source and seq_checker.
// The master drives the stream; the slave (the checker) reports lock and errors.
interface seq_checker_if #(
  parameter int ERR_W = 16
);
  logic             bit_valid;
  logic             bit_in;
  logic             err_clr;
  logic             locked;
  logic             err_pulse;
  logic             period_done;
  logic [ERR_W-1:0] err_count;

  modport master (
    output bit_valid, bit_in, err_clr,
    input  locked, err_pulse, period_done, err_count
  );

  modport slave (
    input  bit_valid, bit_in, err_clr,
    output locked, err_pulse, period_done, err_count
  );
endinterface

// File: rtl/seq_checker.sv
// Serial pattern checker: hunts for PATTERN, aligns, locks, counts bit errors.
// Define SEQ_CHECKER_ERRCNT_EN to build the saturating err_count / err_clr logic.
module seq_checker #(
  parameter int             LEN       = 6,
  parameter logic [LEN-1:0] PATTERN   = 6'b001101,
  parameter int             LOCK_CNT  = 3,
  parameter int             LOSS_ERRS = 2,
  parameter int             ERR_W     = 16
) (
  input  logic        clk,
  input  logic        reset,
  seq_checker_if.slave bus
);

  localparam int PW = $clog2(LEN);
  localparam int FW = $clog2(LEN + 1);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int EW = $clog2(LOSS_ERRS + 1);

  typedef enum logic [1:0] {HUNT, ALIGN, LOCKED} state_e;

  // Reversed copy lets the phase counter index the pattern directly (MSB sent first).
  function automatic logic [LEN-1:0] bit_reverse(input logic [LEN-1:0] v);
    for (int i = 0; i < LEN; i++) bit_reverse[i] = v[LEN-1-i];
  endfunction

  localparam logic [LEN-1:0] PAT_REV = bit_reverse(PATTERN);

  state_e         state_q;
  logic [LEN-1:0] sr_q, sr_d;
  logic [FW-1:0]  fill_q, fill_d;
  logic [PW-1:0]  phase_q, phase_d;
  logic [GW-1:0]  good_q, good_d;
  logic [EW-1:0]  perr_q, perr_d;
  logic           err_pulse_q, period_done_q;
  logic           mismatch, phase_last;

  // NOTE: every signal here gets a value on every path, so no latch is inferred.
  always_comb begin
    mismatch   = bus.bit_in != PAT_REV[phase_q];
    phase_last = phase_q == PW'(LEN - 1);
    phase_d    = phase_last ? '0 : phase_q + 1'b1;
    sr_d       = {sr_q[LEN-2:0], bus.bit_in};
    fill_d     = (fill_q == FW'(LEN)) ? fill_q : fill_q + 1'b1;
    good_d     = good_q + 1'b1;
    perr_d     = perr_q + 1'b1;
  end

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= HUNT;
      sr_q          <= '0;
      fill_q        <= '0;
      phase_q       <= '0;
      good_q        <= '0;
      perr_q        <= '0;
      err_pulse_q   <= 1'b0;
      period_done_q <= 1'b0;
    end else begin
      err_pulse_q   <= 1'b0;
      period_done_q <= 1'b0;
      if (bus.bit_valid) begin
        unique case (state_q)
          HUNT: begin
            sr_q   <= sr_d;
            fill_q <= fill_d;
            if (sr_d == PATTERN && fill_d == FW'(LEN)) begin
              phase_q <= '0;
              good_q  <= GW'(1);
              perr_q  <= '0;
              state_q <= (LOCK_CNT == 1) ? LOCKED : ALIGN;
            end
          end
          ALIGN: begin
            if (mismatch) begin
              state_q <= HUNT;
              fill_q  <= '0;
            end else begin
              phase_q <= phase_d;
              if (phase_last) begin
                good_q <= good_d;
                if (good_d == GW'(LOCK_CNT)) begin
                  state_q <= LOCKED;
                  perr_q  <= '0;
                end
              end
            end
          end
          LOCKED: begin
            err_pulse_q <= mismatch;
            if (mismatch && perr_d == EW'(LOSS_ERRS)) begin
              state_q <= HUNT;
              fill_q  <= '0;
            end else begin
              phase_q       <= phase_d;
              period_done_q <= phase_last;
              perr_q        <= phase_last ? '0 : (mismatch ? perr_d : perr_q);
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

`ifdef SEQ_CHECKER_ERRCNT_EN
  logic [ERR_W-1:0] err_cnt_q;
  logic             err_hit;

  assign err_hit = bus.bit_valid && (state_q == LOCKED) && mismatch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else if (err_hit) begin
      err_cnt_q <= bus.err_clr ? ERR_W'(1) : ((&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1);
    end else if (bus.err_clr) begin
      err_cnt_q <= '0;
    end
  end

  assign bus.err_count = err_cnt_q;
`else
  assign bus.err_count = '0;
`endif

  assign bus.locked      = (state_q == LOCKED);
  assign bus.err_pulse   = err_pulse_q;
  assign bus.period_done = period_done_q;

endmodule
